// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared types and helpers for the domain-B word capture block
// Contents:
//   DEF_DATA_W  default captured word width
//   cdc_word_t  word type at the default width
//   level_w()   width of an occupancy count for a given FIFO depth
package cdc_pkg;

    localparam int DEF_DATA_W = 16;

    typedef logic [DEF_DATA_W-1:0] cdc_word_t;

    // Occupancy must reach DEPTH itself, hence one bit more than the address.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cdc_word_capture_if.sv
// rtl/cdc_word_capture_if.sv - capture/stream/status bundle for cdc_word_capture
// Signals:
//   capture_pulse, data_in   capture request and the quasi-static domain-A word
//   out_valid, out_ready, out_data  head-of-FIFO stream
//   ack_toggle               flips once per word written into the FIFO
//   level                    FIFO occupancy
//   overflow, drop_cnt       sticky drop flag and saturating drop count
//   overflow_clr             clears overflow and drop_cnt
// Modports: slave = the capture block, master = whoever drives it.
interface cdc_word_capture_if
    import cdc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
);
    localparam int LVL_W = level_w(DEPTH);

    logic              capture_pulse;
    logic [DATA_W-1:0] data_in;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              ack_toggle;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic              overflow_clr;
    logic [CNT_W-1:0]  drop_cnt;

    modport slave (
        input  capture_pulse, data_in, out_ready, overflow_clr,
        output out_valid, out_data, ack_toggle, level, overflow, drop_cnt
    );

    modport master (
        output capture_pulse, data_in, out_ready, overflow_clr,
        input  out_valid, out_data, ack_toggle, level, overflow, drop_cnt
    );

endinterface

// File: rtl/cdc_word_capture_sync_fifo_fwft.sv
// rtl/cdc_word_capture_sync_fifo_fwft.sv - first-word-fall-through FIFO with registered head
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   push, push_data      write request (caller guarantees room)
//   pop                  read request (caller guarantees out_valid)
//   full                 occupancy equals DEPTH
//   out_valid, out_data  registered head-of-FIFO word
//   level                occupancy, 0..DEPTH
module sync_fifo_fwft
    import cdc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [level_w(DEPTH)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              valid_q, valid_d;

    // Pointers carry an extra MSB, so their difference is the true occupancy.
    assign level     = wr_ptr_q - rd_ptr_q;
    assign full      = (level == PW'(DEPTH));
    assign out_valid = valid_q;
    assign out_data  = head_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        valid_d = (wr_ptr_d != rd_ptr_d);
        // Reading through mem_d lets a word pushed into an empty FIFO become the head at once.
        head_d  = valid_d ? mem_d[rd_ptr_d[AW-1:0]] : head_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: rtl/cdc_word_capture.sv
// rtl/cdc_word_capture.sv - domain-B capture of a domain-A word into an FWFT FIFO
// Ports:
//   clk_b   domain-B clock
//   rst_b   asynchronous reset, active-high
//   bus     cdc_word_capture_if.slave: capture request, output stream, ack toggle,
//           occupancy, overflow flag/clear and drop counter
// One word that finds the FIFO full is parked in a pend register and written, with
// its ack, on the first cycle that has room. Any capture while a word is parked is
// dropped and counted.
module cdc_word_capture
    import cdc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input logic               clk_b,
    input logic               rst_b,
    cdc_word_capture_if.slave bus
);
    localparam int LVL_W = level_w(DEPTH);

    logic              pend_q, pend_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic              ack_q, ack_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic              full;
    logic              fifo_valid;
    logic [DATA_W-1:0] fifo_data;
    logic [LVL_W-1:0]  fifo_level;
    logic              room;
    logic              drop;

    sync_fifo_fwft #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk_b),
        .rst       (rst_b),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .full      (full),
        .out_valid (fifo_valid),
        .out_data  (fifo_data),
        .level     (fifo_level)
    );

    assign pop  = fifo_valid && bus.out_ready;
    // A same-edge pop frees a slot even when the FIFO reads full.
    assign room = !full || pop;

    always_comb begin
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        ack_d       = ack_q;
        overflow_d  = overflow_q;
        drop_cnt_d  = drop_cnt_q;
        push        = 1'b0;
        push_data   = pend_data_q;
        drop        = 1'b0;

        if (pend_q) begin
            // Only one write per cycle, so the parked word always goes first and
            // any new capture now is lost.
            if (room) begin
                push   = 1'b1;
                pend_d = 1'b0;
                ack_d  = ~ack_q;
            end
            drop = bus.capture_pulse;
        end else if (bus.capture_pulse) begin
            if (room) begin
                push      = 1'b1;
                push_data = bus.data_in;
                ack_d     = ~ack_q;
            end else begin
                pend_d      = 1'b1;
                pend_data_d = bus.data_in;
            end
        end

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != {CNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
        if (bus.overflow_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_b or posedge rst_b) begin
        if (rst_b) begin
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            ack_q       <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            ack_q       <= ack_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign bus.out_valid  = fifo_valid;
    assign bus.out_data   = fifo_data;
    assign bus.level      = fifo_level;
    assign bus.ack_toggle = ack_q;
    assign bus.overflow   = overflow_q;
    assign bus.drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_cdc_word_capture.sv
// tb/tb_cdc_word_capture.sv - self-checking bench for cdc_word_capture
module tb_cdc_word_capture;
    import cdc_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;
    localparam int LVL_W = level_w(DEPTH);

    logic clk_b = 1'b0;
    logic rst_b = 1'b1;
    always #5 clk_b = ~clk_b;

    cdc_word_capture_if #(.DATA_W(16), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    cdc_word_capture #(.DATA_W(16), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_b (clk_b),
        .rst_b (rst_b),
        .bus   (bus)
    );

    int        checks = 0;
    int        errors = 0;
    cdc_word_t exp_q[$];
    logic      exp_ack = 1'b0;

    typedef struct {
        cdc_word_t        data;
        bit               keep;
        bit               flips;
        logic [LVL_W-1:0] exp_level;
        bit               exp_ovf;
        logic [CNT_W-1:0] exp_drop;
    } vec_t;
    vec_t vt[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted word must leave in order.
    always @(negedge clk_b) begin
        if (!rst_b && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected no word", bus.out_data);
            end else begin
                check("pop_data", bus.out_data, exp_q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_b);
        #1;
    endtask

    task automatic pulse(input cdc_word_t d, input bit keep, input bit flips);
        bus.data_in       = d;
        bus.capture_pulse = 1'b1;
        if (keep) exp_q.push_back(d);
        if (flips) exp_ack = ~exp_ack;
        @(posedge clk_b);
        #1;
        bus.capture_pulse = 1'b0;
    endtask

    task automatic drain(input string tag);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) idle(1);
        check({tag, "_drain_left"}, exp_q.size(), 0);
        bus.out_ready = 1'b0;
        check({tag, "_valid_after"}, bus.out_valid, 0);
        check({tag, "_level_after"}, bus.level, 0);
        check({tag, "_ack_after"}, bus.ack_toggle, exp_ack);
    endtask

    task automatic single_word(input string tag);
        bus.out_ready = 1'b1;
        pulse(16'hA5C3, 1'b1, 1'b1);
        check({tag, "_valid"}, bus.out_valid, 1);
        check({tag, "_data"}, bus.out_data, 16'hA5C3);
        check({tag, "_ack"}, bus.ack_toggle, exp_ack);
        check({tag, "_level1"}, bus.level, 1);
        idle(1);
        check({tag, "_level0"}, bus.level, 0);
        check({tag, "_valid0"}, bus.out_valid, 0);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_table(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            pulse(vt[i].data, vt[i].keep, vt[i].flips);
            check($sformatf("%s_level_%0d", tag, i), bus.level, vt[i].exp_level);
            check($sformatf("%s_ack_%0d", tag, i), bus.ack_toggle, exp_ack);
            check($sformatf("%s_ovf_%0d", tag, i), bus.overflow, vt[i].exp_ovf);
            check($sformatf("%s_drop_%0d", tag, i), bus.drop_cnt, vt[i].exp_drop);
            idle(7);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, bus.out_valid, 0);
        check({tag, "_data"}, bus.out_data, 0);
        check({tag, "_ack"}, bus.ack_toggle, 0);
        check({tag, "_level"}, bus.level, 0);
        check({tag, "_ovf"}, bus.overflow, 0);
        check({tag, "_drop"}, bus.drop_cnt, 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++)
            vt[i] = '{cdc_word_t'(16'h1000 + 16'h0111 * i), 1'b1, 1'b1, LVL_W'(i + 1), 1'b0, '0};
        vt[4] = '{16'h5A5A, 1'b1, 1'b0, LVL_W'(4), 1'b0, '0};
        vt[5] = '{16'hDEAD, 1'b0, 1'b0, LVL_W'(4), 1'b1, CNT_W'(1)};

        bus.capture_pulse = 1'b0;
        bus.data_in       = '0;
        bus.out_ready     = 1'b0;
        bus.overflow_clr  = 1'b0;
        idle(2);
        check_reset_state("reset");
        rst_b = 1'b0;
        idle(2);

        // Single word straight through.
        single_word("t1");

        // Five words against a stalled sink: four stored, one parked, then drained.
        run_table(5, "t2");
        exp_ack = ~exp_ack;
        drain("t2");

        // Sixth word is dropped; the five retained words survive.
        run_table(6, "t3");
        bus.overflow_clr = 1'b1;
        idle(1);
        bus.overflow_clr = 1'b0;
        check("t3_clr_ovf", bus.overflow, 0);
        check("t3_clr_drop", bus.drop_cnt, 0);
        exp_ack = ~exp_ack;
        drain("t3");

        // Full FIFO, capture coincident with a pop goes straight in.
        for (int i = 0; i < 4; i++) begin
            pulse(cdc_word_t'(16'h4000 + i), 1'b1, 1'b1);
            idle(3);
        end
        check("t4_full_level", bus.level, 4);
        bus.out_ready = 1'b1;
        pulse(16'hBEEF, 1'b1, 1'b1);
        bus.out_ready = 1'b0;
        check("t4_level_kept", bus.level, 4);
        check("t4_ack", bus.ack_toggle, exp_ack);
        idle(2);
        check("t4_no_pend_level", bus.level, 4);
        drain("t4");

        // Saturating drop counter and clear beating a coincident drop.
        for (int i = 0; i < 4; i++) begin
            pulse(cdc_word_t'(16'h7000 + i), 1'b1, 1'b1);
            idle(3);
        end
        pulse(16'h7777, 1'b1, 1'b0);
        idle(3);
        for (int i = 0; i < 5; i++) begin
            pulse(cdc_word_t'(16'hD000 + i), 1'b0, 1'b0);
            idle(3);
        end
        check("t5_drop_sat", bus.drop_cnt, 3);
        check("t5_ovf_set", bus.overflow, 1);
        check("t5_ack_hold", bus.ack_toggle, exp_ack);
        bus.overflow_clr = 1'b1;
        pulse(16'hD0D0, 1'b0, 1'b0);
        bus.overflow_clr = 1'b0;
        check("t5_clr_ovf", bus.overflow, 0);
        check("t5_clr_drop", bus.drop_cnt, 0);
        check("t5_level", bus.level, 4);

        // Asynchronous reset with a full FIFO and a parked word.
        #2;
        rst_b = 1'b1;
        #1;
        check_reset_state("t6_reset");
        exp_q.delete();
        exp_ack = 1'b0;
        @(posedge clk_b);
        #1;
        rst_b = 1'b0;
        idle(2);
        check_reset_state("t6_after");
        single_word("t6");
        idle(2);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
